// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA frame-buffer write path.
package vga_pkg;

   typedef logic [23:0] colour_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL_WAIT = 2'd1,
      FILL      = 2'd2
   } fbw_state_t;

   localparam int DEF_IMG_W  = 256;
   localparam int DEF_IMG_H  = 256;
   localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding pending {address, colour} frame-buffer writes.
module fb_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("fb_wr_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: buffers CPU pixel writes, drains them to the RAM
// write port during blanking, and performs whole-screen fills.
module fb_write_ctrl
   import vga_pkg::*;
#(
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter bit GATE_BLANK = 1'b1
) (
   input  logic                          clk_25M,
   input  logic                          reset,
   input  logic                          enable_horizontal,
   input  logic                          enable_vertical,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [9:0]                    wr_x,
   input  logic [9:0]                    wr_y,
   input  colour_t                       wr_colour,
   input  logic                          fill_req,
   input  colour_t                       fill_colour,
   output logic                          fill_busy,
   input  logic                          err_clr,
   output logic                          drop_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fb_we,
   output logic [ADDR_W-1:0]             fb_addr,
   output colour_t                       fb_data,
   output fbw_state_t                    state_dbg
);

   localparam int                PIXELS    = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
   localparam int                ENTRY_W   = ADDR_W + 24;

   if (longint'(PIXELS) > (longint'(1) << ADDR_W)) begin : g_size_chk
      $error("fb_write_ctrl: IMG_W*IMG_H does not fit in ADDR_W address bits");
   end

   fbw_state_t        state_q, state_d;
   logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
   colour_t           fill_colour_q, fill_colour_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   colour_t           fb_data_q, fb_data_d;
   logic              drop_err_q, drop_err_d;

   logic              blank, write_ok, in_range, accept, push, pop, fill_wr;
   logic [ADDR_W-1:0] push_addr;
   logic [ENTRY_W-1:0] fifo_dout;
   logic              fifo_full, fifo_empty;

   assign blank     = !(enable_horizontal && enable_vertical);
   assign write_ok  = GATE_BLANK ? blank : 1'b1;
   assign in_range  = (32'(wr_x) < 32'(IMG_W)) && (32'(wr_y) < 32'(IMG_H));
   assign push_addr = ADDR_W'(32'(wr_y) * 32'(IMG_W) + 32'(wr_x));
   assign accept    = wr_valid && wr_ready;
   assign push      = accept && in_range;

   fb_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk_25M),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .din   ({push_addr, wr_colour}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk_25M or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         fill_cnt_q    <= '0;
         fill_colour_q <= '0;
         fb_we_q       <= 1'b0;
         fb_addr_q     <= '0;
         fb_data_q     <= '0;
         drop_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         fill_cnt_q    <= fill_cnt_d;
         fill_colour_q <= fill_colour_d;
         fb_we_q       <= fb_we_d;
         fb_addr_q     <= fb_addr_d;
         fb_data_q     <= fb_data_d;
         drop_err_q    <= drop_err_d;
      end
   end

   // The fill counter only advances on write_ok cycles, so active video pauses it.
   always_comb begin
      state_d       = state_q;
      fill_cnt_d    = fill_cnt_q;
      fill_colour_d = fill_colour_q;
      unique case (state_q)
         IDLE: begin
            if (fill_req) begin
               fill_colour_d = fill_colour;
               state_d       = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (fifo_empty) begin
               fill_cnt_d = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (write_ok) begin
               if (fill_cnt_q == LAST_ADDR) begin
                  fill_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ready  = !fifo_full && (state_q == IDLE);
      fill_busy = (state_q != IDLE);
      pop       = (state_q != FILL) && !fifo_empty && write_ok;
      fill_wr   = (state_q == FILL) && write_ok;
      fb_we_d   = pop || fill_wr;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      if (pop) begin
         fb_addr_d = fifo_dout[ENTRY_W-1 -: ADDR_W];
         fb_data_d = fifo_dout[23:0];
      end else if (fill_wr) begin
         fb_addr_d = fill_cnt_q;
         fb_data_d = fill_colour_q;
      end
      // A new drop takes priority over a clear in the same cycle.
      if (accept && !in_range) begin
         drop_err_d = 1'b1;
      end else if (err_clr) begin
         drop_err_d = 1'b0;
      end else begin
         drop_err_d = drop_err_q;
      end
   end

   assign fb_we     = fb_we_q;
   assign fb_addr   = fb_addr_q;
   assign fb_data   = fb_data_q;
   assign drop_err  = drop_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Randomised and directed bench for fb_write_ctrl against a queue-based reference model.
module tb_fb_write_ctrl;
   import vga_pkg::*;

   localparam int IMG_W  = 256;
   localparam int IMG_H  = 256;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;
   localparam int PIXELS = IMG_W * IMG_H;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              enable_horizontal, enable_vertical;
   logic              wr_valid, wr_valid_ng, wr_ready, wr_ready_ng;
   logic [9:0]        wr_x, wr_y;
   colour_t           wr_colour, fill_colour;
   logic              fill_req, err_clr, tie_zero;
   logic              fill_busy, drop_err, fill_busy_ng, drop_err_ng;
   logic [CNT_W-1:0]  fifo_count, fifo_count_ng;
   logic              fb_we, fb_we_ng;
   logic [ADDR_W-1:0] fb_addr, fb_addr_ng;
   colour_t           fb_data, fb_data_ng;
   fbw_state_t        state_dbg, state_dbg_ng;

   fb_write_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .GATE_BLANK(1'b1)
   ) dut (
      .clk_25M(clk), .reset(rst_n),
      .enable_horizontal(enable_horizontal), .enable_vertical(enable_vertical),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour),
      .fill_req(fill_req), .fill_colour(fill_colour), .fill_busy(fill_busy),
      .err_clr(err_clr), .drop_err(drop_err), .fifo_count(fifo_count),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .state_dbg(state_dbg)
   );

   fb_write_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .GATE_BLANK(1'b0)
   ) dut_ng (
      .clk_25M(clk), .reset(rst_n),
      .enable_horizontal(enable_horizontal), .enable_vertical(enable_vertical),
      .wr_valid(wr_valid_ng), .wr_ready(wr_ready_ng), .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour),
      .fill_req(tie_zero), .fill_colour(fill_colour), .fill_busy(fill_busy_ng),
      .err_clr(tie_zero), .drop_err(drop_err_ng), .fifo_count(fifo_count_ng),
      .fb_we(fb_we_ng), .fb_addr(fb_addr_ng), .fb_data(fb_data_ng), .state_dbg(state_dbg_ng)
   );

   // ---------------- scoreboard / checking ----------------
   int tests_run    = 0;
   int tests_failed = 0;
   bit chk_en       = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending writes in order, plus the fill request lifecycle.
   logic [ADDR_W+23:0] exp_q[$];
   bit                 m_armed, m_filling, m_we, m_drop;
   int                 m_pos;
   logic [ADDR_W-1:0]  m_addr;
   colour_t            m_data, m_fill_col;

   task automatic model_clear();
      exp_q.delete();
      m_armed = 0; m_filling = 0; m_we = 0; m_drop = 0; m_pos = 0;
      m_addr = '0; m_data = '0; m_fill_col = '0;
   endtask

   task automatic model_step();
      bit ok, rdy, was_armed, was_filling, was_empty, drop_set;
      ok          = !(enable_horizontal && enable_vertical);
      was_armed   = m_armed;
      was_filling = m_filling;
      was_empty   = (exp_q.size() == 0);
      rdy         = (exp_q.size() < DEPTH) && !m_armed && !m_filling;
      drop_set    = 1'b0;
      m_we        = 1'b0;
      if (!was_filling && !was_empty && ok) begin
         {m_addr, m_data} = exp_q.pop_front();
         m_we = 1'b1;
      end else if (was_filling && ok) begin
         m_addr = ADDR_W'(m_pos);
         m_data = m_fill_col;
         m_we   = 1'b1;
         m_pos++;
         if (m_pos == PIXELS) m_filling = 1'b0;
      end
      if (wr_valid && rdy) begin
         if (int'(wr_x) < IMG_W && int'(wr_y) < IMG_H)
            exp_q.push_back({ADDR_W'(int'(wr_y) * IMG_W + int'(wr_x)), wr_colour});
         else
            drop_set = 1'b1;
      end
      if (drop_set) m_drop = 1'b1;
      else if (err_clr) m_drop = 1'b0;
      if (!was_armed && !was_filling && fill_req) begin
         m_armed    = 1'b1;
         m_fill_col = fill_colour;
      end else if (was_armed && was_empty) begin
         m_armed   = 1'b0;
         m_filling = 1'b1;
         m_pos     = 0;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) model_clear();
      else model_step();
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("fb_we", fb_we, m_we);
         check("fb_addr", fb_addr, m_addr);
         check("fb_data", fb_data, m_data);
         check("fifo_count", fifo_count, 64'(exp_q.size()));
         check("wr_ready", wr_ready, (exp_q.size() < DEPTH) && !m_armed && !m_filling);
         check("fill_busy", fill_busy, m_armed || m_filling);
         check("drop_err", drop_err, m_drop);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_px(input int x, input int y, input colour_t c);
      wr_valid  = 1'b1;
      wr_x      = 10'(x);
      wr_y      = 10'(y);
      wr_colour = c;
      @(negedge clk);
      wr_valid  = 1'b0;
   endtask

   task automatic set_video(input bit active);
      enable_horizontal = active;
      enable_vertical   = active;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int  n_we;
      bit  found, prev_busy;
      logic [ADDR_W-1:0] last_addr;

      rst_n = 1'b0; tie_zero = 1'b0;
      enable_horizontal = 1'b0; enable_vertical = 1'b0;
      wr_valid = 1'b0; wr_valid_ng = 1'b0; wr_x = '0; wr_y = '0; wr_colour = '0;
      fill_req = 1'b0; fill_colour = '0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_fb_we", fb_we, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_data", fb_data, 0);
      check("rst_drop_err", drop_err, 0);
      check("rst_fill_busy", fill_busy, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_state", state_dbg, IDLE);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Single write in blanking: visible the cycle after the draining edge.
      set_video(0);
      drive_px(3, 2, 24'hFF0000);
      check("t1_we_early", fb_we, 0);
      @(negedge clk);
      check("t1_we", fb_we, 1);
      check("t1_addr", fb_addr, 515);
      check("t1_data", fb_data, 24'hFF0000);
      @(negedge clk);
      check("t1_we_single", fb_we, 0);

      // Five writes during active video: only four fit.
      set_video(1);
      wr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_x = 10'(10 + i); wr_y = 10'd5; wr_colour = 24'(i + 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      check("t2_count_full", fifo_count, 4);
      check("t2_ready_full", wr_ready, 0);
      check("t2_no_we", fb_we, 0);
      set_video(0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t2_drain_we", fb_we, 1);
         check("t2_drain_addr", fb_addr, 5 * IMG_W + 10 + i);
         check("t2_drain_data", fb_data, i + 1);
      end
      @(negedge clk);
      check("t2_idle_we", fb_we, 0);
      check("t2_ready_back", wr_ready, 1);

      // Out-of-range drop and sticky error behaviour.
      drive_px(300, 0, 24'h123456);
      check("t3_drop_set", drop_err, 1);
      @(negedge clk);
      check("t3_drop_no_we", fb_we, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t3_drop_clr", drop_err, 0);
      err_clr = 1'b1;
      drive_px(0, 400, 24'h654321);
      err_clr = 1'b0;
      check("t3_set_wins", drop_err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;

      // Randomised traffic with random blanking.
      for (int c = 0; c < 2000; c++) begin
         enable_horizontal = ($urandom_range(0, 3) != 0);
         enable_vertical   = $urandom_range(0, 1) == 1;
         wr_valid  = $urandom_range(0, 1) == 1;
         wr_x      = 10'($urandom_range(0, 299));
         wr_y      = 10'($urandom_range(0, 270));
         wr_colour = 24'($urandom);
         err_clr   = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      wr_valid = 1'b0; err_clr = 1'b0;
      set_video(0);
      repeat (6) @(negedge clk);

      // Fill with two pending writes; one write arrives with the fill request.
      set_video(1);
      drive_px(10, 10, 24'hAA0001);
      wr_valid = 1'b1; wr_x = 10'd20; wr_y = 10'd20; wr_colour = 24'hAA0002;
      fill_req = 1'b1; fill_colour = 24'h0000FF;
      @(negedge clk);
      wr_valid = 1'b0; fill_req = 1'b0;
      check("t4_busy", fill_busy, 1);
      check("t4_pending", fifo_count, 2);
      n_we = 0; prev_busy = 1'b1; last_addr = '0;
      for (int c = 0; c < 80000 && (m_armed || m_filling); c++) begin
         set_video($urandom_range(0, 31) == 0);
         fill_req    = ($urandom_range(0, 63) == 0);
         fill_colour = 24'($urandom);
         wr_valid    = $urandom_range(0, 1) == 1;
         wr_x        = 10'($urandom_range(0, 255));
         @(negedge clk);
         if (fb_we) begin
            n_we++;
            last_addr = fb_addr;
            if (fb_addr == 16'hFFFF && fb_data == 24'h0000FF) begin
               check("t4_busy_before_last", prev_busy, 1);
               check("t4_busy_falls", fill_busy, 0);
            end
         end
         prev_busy = fill_busy;
      end
      fill_req = 1'b0; wr_valid = 1'b0;
      set_video(0);
      check("t4_write_total", n_we, PIXELS + 2);
      check("t4_last_addr", last_addr, PIXELS - 1);
      check("t4_done_busy", fill_busy, 0);
      check("t4_done_state", state_dbg, IDLE);

      // Reset in the middle of a fill.
      fill_colour = 24'h00A5A5; fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 3000 && !found; c++) begin
         @(negedge clk);
         if (fb_we && fb_addr == 16'd1000) found = 1'b1;
      end
      check("t5_reach_1000", found, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_we", fb_we, 0);
      check("t5_rst_state", state_dbg, IDLE);
      check("t5_rst_busy", fill_busy, 0);
      check("t5_rst_count", fifo_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_we = 0;
      repeat (20) begin
         @(negedge clk);
         if (fb_we) n_we++;
      end
      check("t5_quiet_after", n_we, 0);
      check("t5_busy_after", fill_busy, 0);

      // Ungated instance writes during active video at minimum latency.
      set_video(1);
      for (int i = 0; i < 4; i++) begin
         int x, y;
         colour_t c;
         x = $urandom_range(0, IMG_W - 1);
         y = $urandom_range(0, IMG_H - 1);
         c = 24'($urandom);
         wr_valid_ng = 1'b1; wr_x = 10'(x); wr_y = 10'(y); wr_colour = c;
         @(negedge clk);
         wr_valid_ng = 1'b0;
         check("t6_we_early", fb_we_ng, 0);
         @(negedge clk);
         check("t6_we", fb_we_ng, 1);
         check("t6_addr", fb_addr_ng, y * IMG_W + x);
         check("t6_data", fb_data_ng, c);
         @(negedge clk);
         check("t6_we_single", fb_we_ng, 0);
      end
      check("t6_gated_idle", fb_we, 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
